// File: rtl/taxi_axis_fifo_pause_ctrl.sv
// Flow/pause controller for one side of a taxi_axis async FIFO: XOFF hysteresis,
// software pause handshake with a minimum pause time, and saturating frame statistics.
module taxi_axis_fifo_pause_ctrl #(
    parameter int DEPTH_W   = 13,
    parameter int MIN_PAUSE = 16,
    parameter int CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_enable,
    input  logic [DEPTH_W-1:0] cfg_xoff_thresh,
    input  logic [DEPTH_W-1:0] cfg_xon_thresh,
    input  logic [DEPTH_W-1:0] status_depth,
    input  logic               status_overflow,
    input  logic               status_bad_frame,
    input  logic               status_good_frame,
    input  logic               sw_pause_req,
    output logic               sw_pause_ack,
    output logic               pause_req,
    input  logic               pause_ack,
    output logic               xoff,
    input  logic               cnt_clear,
    output logic [CNT_W-1:0]   cnt_good,
    output logic [CNT_W-1:0]   cnt_bad,
    output logic [CNT_W-1:0]   cnt_overflow,
    output logic [1:0]         state
);

    localparam int HOLD_W = (MIN_PAUSE > 1) ? $clog2(MIN_PAUSE) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_PAUSE - 1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_REQ    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    state_t            state_q;
    logic [HOLD_W-1:0] hold_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign state = state_q;

    // Set wins over clear so an inverted xon/xoff configuration still resolves.
    always_ff @(posedge clk) begin
        if (rst || !cfg_enable) begin
            xoff <= 1'b0;
        end else if (status_depth >= cfg_xoff_thresh) begin
            xoff <= 1'b1;
        end else if (status_depth <= cfg_xon_thresh) begin
            xoff <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pause_req    <= 1'b0;
            sw_pause_ack <= 1'b0;
            hold_cnt     <= '0;
        end else begin
            // Hold timer runs from the first PAUSED cycle until it drains to zero.
            if ((state_q == ST_PAUSED || state_q == ST_HOLD) && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HOLD_W'(1);
            end
            case (state_q)
                ST_RUN: begin
                    if (sw_pause_req) begin
                        state_q   <= ST_REQ;
                        pause_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (pause_ack) begin
                        state_q      <= ST_PAUSED;
                        sw_pause_ack <= 1'b1;
                        hold_cnt     <= HOLD_LOAD;
                    end else if (!sw_pause_req) begin
                        state_q   <= ST_RUN;
                        pause_req <= 1'b0;
                    end
                end
                ST_PAUSED: begin
                    if (!pause_ack) begin
                        state_q      <= ST_REQ;
                        sw_pause_ack <= 1'b0;
                    end else if (!sw_pause_req) begin
                        state_q      <= ST_HOLD;
                        sw_pause_ack <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    // A lost ack means the FIFO was reset under us: re-request.
                    if (!pause_ack) begin
                        state_q <= ST_REQ;
                    end else if (sw_pause_req) begin
                        state_q      <= ST_PAUSED;
                        sw_pause_ack <= 1'b1;
                    end else if (hold_cnt == '0) begin
                        state_q   <= ST_RUN;
                        pause_req <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_RUN;
                    pause_req    <= 1'b0;
                    sw_pause_ack <= 1'b0;
                end
            endcase
        end
    end

    // Clear beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cnt_good     <= '0;
            cnt_bad      <= '0;
            cnt_overflow <= '0;
        end else begin
            if (status_good_frame) cnt_good <= sat_inc(cnt_good);
            if (status_bad_frame) cnt_bad <= sat_inc(cnt_bad);
            if (status_overflow) cnt_overflow <= sat_inc(cnt_overflow);
        end
    end

endmodule

// File: tb/tb_taxi_axis_fifo_pause_ctrl.sv
// Directed scoreboard bench for taxi_axis_fifo_pause_ctrl (default instance plus a 4-bit counter instance).
module tb_taxi_axis_fifo_pause_ctrl;

    localparam int DW = 13;
    localparam int MP = 16;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_enable;
    logic [DW-1:0] cfg_xoff_thresh, cfg_xon_thresh, status_depth;
    logic          status_overflow, status_bad_frame, status_good_frame;
    logic          sw_pause_req, pause_ack, cnt_clear;
    logic          sw_pause_ack, pause_req, xoff;
    logic [CW-1:0] cnt_good, cnt_bad, cnt_overflow;
    logic [1:0]    state;
    logic          sw_pause_ack4, pause_req4, xoff4;
    logic [3:0]    cnt_good4, cnt_bad4, cnt_overflow4;
    logic [1:0]    state4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    taxi_axis_fifo_pause_ctrl #(.DEPTH_W(DW), .MIN_PAUSE(MP), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
        .cfg_xoff_thresh(cfg_xoff_thresh), .cfg_xon_thresh(cfg_xon_thresh),
        .status_depth(status_depth), .status_overflow(status_overflow),
        .status_bad_frame(status_bad_frame), .status_good_frame(status_good_frame),
        .sw_pause_req(sw_pause_req), .sw_pause_ack(sw_pause_ack),
        .pause_req(pause_req), .pause_ack(pause_ack), .xoff(xoff),
        .cnt_clear(cnt_clear), .cnt_good(cnt_good), .cnt_bad(cnt_bad),
        .cnt_overflow(cnt_overflow), .state(state)
    );

    taxi_axis_fifo_pause_ctrl #(.DEPTH_W(DW), .MIN_PAUSE(MP), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .cfg_enable(cfg_enable),
        .cfg_xoff_thresh(cfg_xoff_thresh), .cfg_xon_thresh(cfg_xon_thresh),
        .status_depth(status_depth), .status_overflow(status_overflow),
        .status_bad_frame(status_bad_frame), .status_good_frame(status_good_frame),
        .sw_pause_req(sw_pause_req), .sw_pause_ack(sw_pause_ack4),
        .pause_req(pause_req4), .pause_ack(pause_ack), .xoff(xoff4),
        .cnt_clear(cnt_clear), .cnt_good(cnt_good4), .cnt_bad(cnt_bad4),
        .cnt_overflow(cnt_overflow4), .state(state4)
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    function automatic logic [31:0] observe(int sel);
        case (sel)
            0: return 32'(state);
            1: return 32'(pause_req);
            2: return 32'(sw_pause_ack);
            3: return 32'(xoff);
            4: return cnt_good;
            5: return cnt_bad;
            6: return cnt_overflow;
            7: return 32'(cnt_good4);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic push_exp(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic push_ctl(input string tag, input int st, input int pr, input int ack);
        push_exp({tag, "_state"}, 0, 32'(st));
        push_exp({tag, "_pause_req"}, 1, 32'(pr));
        push_exp({tag, "_sw_ack"}, 2, 32'(ack));
    endtask

    task automatic push_cnt(input string tag, input int g, input int b, input int o, input int g4);
        push_exp({tag, "_good"}, 4, 32'(g));
        push_exp({tag, "_bad"}, 5, 32'(b));
        push_exp({tag, "_ovf"}, 6, 32'(o));
        push_exp({tag, "_good4"}, 7, 32'(g4));
    endtask

    // Advance one clock, then drain the scoreboard against the freshly registered outputs.
    task automatic tick();
        exp_t        e;
        logic [31:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $display("FAIL %s: observed %0d expected %0d", e.tag, obs, e.exp);
                $error("check %s observed %0d expected %0d", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        cfg_enable = 1'b0;
        cfg_xoff_thresh = '0;
        cfg_xon_thresh = '0;
        status_depth = '0;
        status_overflow = 1'b0;
        status_bad_frame = 1'b0;
        status_good_frame = 1'b0;
        sw_pause_req = 1'b0;
        pause_ack = 1'b0;
        cnt_clear = 1'b0;
        #2;
        tick();
        push_ctl("reset", 0, 0, 0);
        push_exp("reset_xoff", 3, 0);
        push_cnt("reset", 0, 0, 0, 0);
        tick();
        rst = 1'b0;

        // XOFF hysteresis ramp
        cfg_enable = 1'b1;
        cfg_xoff_thresh = 13'd100;
        cfg_xon_thresh = 13'd40;
        status_depth = 13'd99;
        push_exp("xoff_d99", 3, 0);
        tick();
        for (int d = 0; d <= 120; d += 10) begin
            status_depth = DW'(d);
            push_exp($sformatf("xoff_up_d%0d", d), 3, (d >= 100) ? 1 : 0);
            tick();
        end
        for (int d = 120; d >= 0; d -= 10) begin
            status_depth = DW'(d);
            push_exp($sformatf("xoff_dn_d%0d", d), 3, (d > 40) ? 1 : 0);
            tick();
        end

        // Inverted thresholds: set wins, then enable gate
        cfg_xoff_thresh = 13'd50;
        cfg_xon_thresh = 13'd80;
        status_depth = 13'd60;
        push_exp("xoff_inverted", 3, 1);
        tick();
        cfg_enable = 1'b0;
        push_exp("xoff_disabled", 3, 0);
        tick();
        push_exp("xoff_disabled_hold", 3, 0);
        tick();

        // Pause handshake with minimum pause time
        sw_pause_req = 1'b1;
        push_ctl("hs_t1", 1, 1, 0);
        tick();
        for (int c = 2; c <= 5; c++) begin
            push_ctl($sformatf("hs_t%0d", c), 1, 1, 0);
            tick();
        end
        pause_ack = 1'b1;
        push_ctl("hs_t6", 2, 1, 1);
        tick();
        push_ctl("hs_t7", 2, 1, 1);
        tick();
        push_ctl("hs_t8", 2, 1, 1);
        tick();
        sw_pause_req = 1'b0;
        push_ctl("hs_t9", 3, 1, 0);
        tick();
        for (int c = 10; c <= 5 + MP; c++) begin
            push_ctl($sformatf("hs_t%0d", c), 3, 1, 0);
            tick();
        end
        push_ctl("hs_release", 0, 0, 0);
        tick();
        pause_ack = 1'b0;

        // Abort without ack: pause_req high exactly two cycles
        sw_pause_req = 1'b1;
        push_ctl("abort_a", 1, 1, 0);
        tick();
        push_ctl("abort_b", 1, 1, 0);
        tick();
        sw_pause_req = 1'b0;
        push_ctl("abort_run", 0, 0, 0);
        tick();

        // Reassert in HOLD keeps the original hold count
        sw_pause_req = 1'b1;
        push_ctl("re_req", 1, 1, 0);
        tick();
        pause_ack = 1'b1;
        push_ctl("re_paused", 2, 1, 1);
        tick();
        sw_pause_req = 1'b0;
        push_ctl("re_hold", 3, 1, 0);
        tick();
        sw_pause_req = 1'b1;
        push_ctl("re_back", 2, 1, 1);
        tick();
        sw_pause_req = 1'b0;
        push_ctl("re_hold2", 3, 1, 0);
        tick();
        for (int c = 0; c < MP - 4; c++) begin
            push_ctl($sformatf("re_wait%0d", c), 3, 1, 0);
            tick();
        end
        push_ctl("re_run", 0, 0, 0);
        tick();
        pause_ack = 1'b0;

        // Ack lost while paused
        sw_pause_req = 1'b1;
        push_ctl("ackdrop_req", 1, 1, 0);
        tick();
        pause_ack = 1'b1;
        push_ctl("ackdrop_paused", 2, 1, 1);
        tick();
        pause_ack = 1'b0;
        push_ctl("ackdrop_rereq", 1, 1, 0);
        tick();
        sw_pause_req = 1'b0;
        push_ctl("ackdrop_run", 0, 0, 0);
        tick();

        // Counters
        status_good_frame = 1'b1;
        push_cnt("cnt1", 1, 0, 0, 1);
        tick();
        status_bad_frame = 1'b1;
        push_cnt("cnt2", 2, 1, 0, 2);
        tick();
        status_good_frame = 1'b0;
        push_cnt("cnt3", 2, 2, 0, 2);
        tick();
        status_bad_frame = 1'b0;
        status_overflow = 1'b1;
        push_cnt("cnt4", 2, 2, 1, 2);
        tick();
        status_overflow = 1'b0;
        status_good_frame = 1'b1;
        push_cnt("cnt5", 3, 2, 1, 3);
        tick();
        cnt_clear = 1'b1;
        push_cnt("cnt_clear", 0, 0, 0, 0);
        tick();
        cnt_clear = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            push_cnt($sformatf("sat%0d", i), i, 0, 0, (i > 15) ? 15 : i);
            tick();
        end
        status_good_frame = 1'b0;

        // Reset while PAUSED with xoff asserted
        cfg_enable = 1'b1;
        cfg_xoff_thresh = 13'd100;
        cfg_xon_thresh = 13'd40;
        status_depth = 13'd120;
        sw_pause_req = 1'b1;
        push_ctl("mid_req", 1, 1, 0);
        push_exp("mid_xoff", 3, 1);
        tick();
        pause_ack = 1'b1;
        status_bad_frame = 1'b1;
        push_ctl("mid_paused", 2, 1, 1);
        push_cnt("mid", 20, 1, 0, 15);
        tick();
        status_bad_frame = 1'b0;
        rst = 1'b1;
        push_ctl("mid_rst", 0, 0, 0);
        push_exp("mid_rst_xoff", 3, 0);
        push_cnt("mid_rst", 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        push_ctl("post_rst_req", 1, 1, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
